// File: rtl/pla_preimage_scan.sv
// Sweeps every input vector into an attached PLA and streams back the vectors
// whose response matches a masked target code over a valid/ready port.
module pla_preimage_scan #(
  parameter int N_IN   = 10,
  parameter int N_OUT  = 4,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [N_OUT-1:0]  target,
  input  logic [N_OUT-1:0]  mask,
  output logic [N_IN-1:0]   pla_x,
  input  logic [N_OUT-1:0]  pla_z,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [N_IN-1:0]   m_data,
  output logic              busy,
  output logic              done,
  output logic [N_IN:0]     match_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [N_IN-1:0] LAST_CAND = '1;
  localparam logic [3:0]      WAIT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  // With no settle time the PLA is purely combinational, so go straight to CHECK.
  localparam logic [2:0]      S_NEXT    = (SETTLE > 0) ? S_SETTLE : S_CHECK;

  logic [2:0]       state;
  logic [N_IN-1:0]  cand;
  logic [3:0]       wait_cnt;
  logic [N_OUT-1:0] target_q;
  logic [N_OUT-1:0] mask_q;
  logic             hit;
  logic             advance;

  assign hit     = ((pla_z ^ target_q) & mask_q) == '0;
  assign advance = ((state == S_CHECK) && !hit) || ((state == S_EMIT) && m_ready);

  // The candidate register drives the PLA directly, so it stays put through EMIT.
  assign pla_x   = cand;
  assign m_valid = (state == S_EMIT);
  assign busy    = (state == S_SETTLE) || (state == S_CHECK) || (state == S_EMIT);
  assign done    = (state == S_FIN);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the advance block may override the case's state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cand        <= '0;
      wait_cnt    <= '0;
      target_q    <= '0;
      mask_q      <= '0;
      m_data      <= '0;
      match_count <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            target_q    <= target;
            mask_q      <= mask;
            match_count <= '0;
            cand        <= '0;
            wait_cnt    <= WAIT_LOAD;
            state       <= S_NEXT;
          end
        end
        S_SETTLE: begin
          if (wait_cnt == 4'd0) state <= S_CHECK;
          else                  wait_cnt <= wait_cnt - 1'b1;
        end
        S_CHECK: begin
          if (hit) begin
            m_data <= cand;
            state  <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (m_ready) match_count <= match_count + 1'b1;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (advance) begin
        if (cand == LAST_CAND) begin
          state <= S_FIN;
        end else begin
          cand     <= cand + 1'b1;
          wait_cnt <= WAIT_LOAD;
          state    <= S_NEXT;
        end
      end
    end
  end

endmodule
